trigger_barrier: RTL and testbench

Network-level counterpart of the per-actor trigger FSMs: collects every trigger's `sleep` / `sync_exec` / `sync_wait` / `ap_idle` status and external input-FIFO write strobes. It produces the broadcast `all_sleep`, `all_sync`, `all_sync_wait` and `external_enqueue` signals the triggers consume. It also owns the network's `ap_start` / `ap_done` handshake toward the host-side kernel wrapper. One instance sits in each generated network top, between the triggers and the input stage.

---
 rtl/trigger_barrier_pkg.sv | 11 +
 rtl/trigger_barrier_enqueue_tracker.sv | 74 +++++++
 rtl/trigger_barrier.sv | 123 ++++++++++++
 tb/tb_trigger_barrier.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_barrier_pkg.sv
// Shared types for the trigger barrier: FSM state encoding and counter width.
package BarrierTypes;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } barrier_state_t;

   localparam int ROUND_COUNT_W = 16;
endpackage

// File: rtl/trigger_barrier_enqueue_tracker.sv
// Pending external-enqueue flag (set wins over clear) and, when TRIGGER_BARRIER_STATS_EN
// is defined, the saturating sync-round counter.
module enqueue_tracker
   import BarrierTypes::*;
#(
   parameter int NUM_INPUTS = 2
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     flush_i,
   input  logic                     sleep_seen_i,
   input  logic [NUM_INPUTS-1:0]    write_i,
   input  logic                     round_clear_i,
   input  logic                     round_inc_i,
   output logic                     pending_o,
   output logic                     pending_next_o,
   output logic [ROUND_COUNT_W-1:0] round_count_o
);

   logic pending_q;
   logic pending_d;

   // A write landing in the same cycle as the all_sleep pulse must survive it.
   always_comb begin
      pending_d = pending_q;
      if (flush_i) begin
         pending_d = 1'b0;
      end else if (|write_i) begin
         pending_d = 1'b1;
      end else if (sleep_seen_i) begin
         pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending_o      = pending_q;
   assign pending_next_o = pending_d;

`ifdef TRIGGER_BARRIER_STATS_EN
   logic [ROUND_COUNT_W-1:0] round_q;
   logic [ROUND_COUNT_W-1:0] round_d;

   always_comb begin
      round_d = round_q;
      if (round_clear_i) begin
         round_d = '0;
      end else if (round_inc_i && (round_q != '1)) begin
         round_d = round_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         round_q <= '0;
      end else begin
         round_q <= round_d;
      end
   end

   assign round_count_o = round_q;
`else
   logic unused_round_inputs;
   assign unused_round_inputs = round_clear_i ^ round_inc_i;
   assign round_count_o       = '0;
`endif

endmodule

// File: rtl/trigger_barrier.sv
// Network-level barrier: aggregates trigger status into one-cycle broadcast pulses and
// owns the ap_start/ap_done handshake. Optional stats via TRIGGER_BARRIER_STATS_EN.
module trigger_barrier
   import BarrierTypes::*;
#(
   parameter int NUM_ACTORS = 4,
   parameter int NUM_INPUTS = 2
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst,
   input  logic                     ap_start,
   output logic                     ap_done,
   output logic                     ap_ready,
   output logic                     ap_idle,
   output logic                     trigger_start,
   input  logic [NUM_ACTORS-1:0]    actor_sleep,
   input  logic [NUM_ACTORS-1:0]    actor_sync_exec,
   input  logic [NUM_ACTORS-1:0]    actor_sync_wait,
   input  logic [NUM_ACTORS-1:0]    actor_idle,
   input  logic [NUM_INPUTS-1:0]    input_write,
   output logic                     all_sleep,
   output logic                     all_sync,
   output logic                     all_sync_wait,
   output logic                     external_enqueue,
   output logic [ROUND_COUNT_W-1:0] round_count
);

   barrier_state_t state_q;
   barrier_state_t state_d;

   logic [NUM_ACTORS-1:0] sync_any;
   logic all_sleep_q,     all_sleep_d;
   logic all_sync_q,      all_sync_d;
   logic all_sync_wait_q, all_sync_wait_d;
   logic pending_q;
   logic pending_d;
   logic run_next;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      ap_idle       = 1'b0;
      trigger_start = 1'b0;
      ap_done       = 1'b0;
      case (state_q)
         IDLE: begin
            ap_idle = 1'b1;
            if (ap_start) begin
               state_d = START;
            end
         end
         START: begin
            trigger_start = 1'b1;
            state_d       = RUN;
         end
         RUN: begin
            if (&actor_idle) begin
               state_d = DONE;
            end
         end
         DONE: begin
            ap_done = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ap_ready = ap_done;

   for (genvar gi = 0; gi < NUM_ACTORS; gi++) begin : g_sync_any
      assign sync_any[gi] = actor_sync_exec[gi] | actor_sync_wait[gi];
   end

   // Aggregates are gated on the state they will be visible in, so they never leak into DONE.
   assign run_next = (state_d == RUN);

   always_comb begin
      all_sleep_d     = run_next & (&actor_sleep) & ~all_sleep_q;
      all_sync_d      = run_next & (&sync_any) & ~all_sync_q;
      all_sync_wait_d = run_next & (&actor_sync_wait) & ~pending_d & ~all_sync_wait_q;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         all_sleep_q     <= 1'b0;
         all_sync_q      <= 1'b0;
         all_sync_wait_q <= 1'b0;
      end else begin
         all_sleep_q     <= all_sleep_d;
         all_sync_q      <= all_sync_d;
         all_sync_wait_q <= all_sync_wait_d;
      end
   end

   enqueue_tracker #(
      .NUM_INPUTS(NUM_INPUTS)
   ) u_enqueue_tracker (
      .clk           (ap_clk),
      .srst          (ap_rst),
      .flush_i       (state_d == IDLE),
      .sleep_seen_i  (all_sleep_q),
      .write_i       (input_write),
      .round_clear_i (state_q == START),
      .round_inc_i   (all_sync_q),
      .pending_o     (pending_q),
      .pending_next_o(pending_d),
      .round_count_o (round_count)
   );

   assign all_sleep        = all_sleep_q;
   assign all_sync         = all_sync_q;
   assign all_sync_wait    = all_sync_wait_q;
   assign external_enqueue = pending_q;

endmodule

// File: tb/tb_trigger_barrier.sv
// Self-checking bench for trigger_barrier: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the handshake and broadcast rules.
module tb_trigger_barrier;

   localparam int NA = 4;
   localparam int NI = 2;
`ifdef TRIGGER_BARRIER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   localparam int P_IDLE  = 0;
   localparam int P_START = 1;
   localparam int P_RUN   = 2;
   localparam int P_DONE  = 3;

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic          ap_start;
   logic          ap_done, ap_ready, ap_idle, trigger_start;
   logic [NA-1:0] actor_sleep, actor_sync_exec, actor_sync_wait, actor_idle;
   logic [NI-1:0] input_write;
   logic          all_sleep, all_sync, all_sync_wait, external_enqueue;
   logic [15:0]   round_count;

   int n_cmp = 0;
   int n_bad = 0;

   int m_phase  = P_IDLE;
   bit m_sleep  = 1'b0;
   bit m_sync   = 1'b0;
   bit m_syncw  = 1'b0;
   bit m_pend   = 1'b0;
   int m_rounds = 0;

   always #5 ap_clk = ~ap_clk;

   trigger_barrier #(.NUM_ACTORS(NA), .NUM_INPUTS(NI)) dut (
      .ap_clk          (ap_clk),
      .ap_rst          (ap_rst),
      .ap_start        (ap_start),
      .ap_done         (ap_done),
      .ap_ready        (ap_ready),
      .ap_idle         (ap_idle),
      .trigger_start   (trigger_start),
      .actor_sleep     (actor_sleep),
      .actor_sync_exec (actor_sync_exec),
      .actor_sync_wait (actor_sync_wait),
      .actor_idle      (actor_idle),
      .input_write     (input_write),
      .all_sleep       (all_sleep),
      .all_sync        (all_sync),
      .all_sync_wait   (all_sync_wait),
      .external_enqueue(external_enqueue),
      .round_count     (round_count)
   );

   // Advance one clock; the model consumes the inputs visible before the edge.
   task automatic tick();
      int np;
      bit ns, nsy, nsw, npd;
      int nr;
      if (ap_rst) begin
         np = P_IDLE; ns = 0; nsy = 0; nsw = 0; npd = 0; nr = 0;
      end else begin
         case (m_phase)
            P_IDLE:  np = ap_start ? P_START : P_IDLE;
            P_START: np = P_RUN;
            P_RUN:   np = (actor_idle == {NA{1'b1}}) ? P_DONE : P_RUN;
            default: np = P_IDLE;
         endcase
         if (np == P_IDLE)          npd = 1'b0;
         else if (input_write != 0) npd = 1'b1;
         else if (m_sleep)          npd = 1'b0;
         else                       npd = m_pend;
         ns  = (np == P_RUN) && (actor_sleep == {NA{1'b1}}) && !m_sleep;
         nsy = (np == P_RUN) && ((actor_sync_exec | actor_sync_wait) == {NA{1'b1}}) && !m_sync;
         nsw = (np == P_RUN) && (actor_sync_wait == {NA{1'b1}}) && !npd && !m_syncw;
         if (!STATS)                nr = 0;
         else if (m_phase == P_START) nr = 0;
         else if (m_sync && m_rounds < 65535) nr = m_rounds + 1;
         else                       nr = m_rounds;
      end
      @(posedge ap_clk);
      m_phase = np; m_sleep = ns; m_sync = nsy; m_syncw = nsw; m_pend = npd; m_rounds = nr;
      #1;
   endtask

   task automatic go_run();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      ap_rst = 1'b1; ap_start = 1'b0;
      actor_sleep = '0; actor_sync_exec = '0; actor_sync_wait = '0; actor_idle = '0;
      input_write = '0;
      tick();
      tick();
      ap_rst = 1'b0;
      n_cmp++;
      if ({ap_idle, ap_done, ap_ready, trigger_start} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_handshake: got %b want 1000", {ap_idle, ap_done, ap_ready, trigger_start});
      end
      n_cmp++;
      if ({all_sleep, all_sync, all_sync_wait, external_enqueue} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_aggregates: got %b want 0000", {all_sleep, all_sync, all_sync_wait, external_enqueue});
      end
      n_cmp++;
      if (round_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_rounds: got %0d want 0", round_count);
      end
      $display("test_reset done: %0d compared", n_cmp);
   endtask

   task automatic test_handshake();
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      n_cmp++;
      if ({trigger_start, ap_idle} !== 2'b10) begin
         n_bad++;
         $display("FAIL start_pulse: got ts/idle=%b want 10", {trigger_start, ap_idle});
      end
      tick();
      n_cmp++;
      if ({trigger_start, ap_idle, ap_done} !== 3'b000) begin
         n_bad++;
         $display("FAIL run_entry: got ts/idle/done=%b want 000", {trigger_start, ap_idle, ap_done});
      end
      ap_start = 1'b1;
      tick();
      ap_start = 1'b0;
      n_cmp++;
      if ({trigger_start, ap_idle, ap_done} !== 3'b000) begin
         n_bad++;
         $display("FAIL start_ignored_in_run: got ts/idle/done=%b want 000", {trigger_start, ap_idle, ap_done});
      end
      $display("test_handshake done: %0d compared", n_cmp);
   endtask

   task automatic test_sleep_rearm();
      actor_sleep = 4'b1111;
      tick();
      n_cmp++;
      if (all_sleep !== 1'b1) begin
         n_bad++;
         $display("FAIL sleep_first: got %b want 1", all_sleep);
      end
      tick();
      n_cmp++;
      if (all_sleep !== 1'b0) begin
         n_bad++;
         $display("FAIL sleep_rearm: got %b want 0", all_sleep);
      end
      actor_sleep = 4'b0111;
      tick();
      n_cmp++;
      if (all_sleep !== 1'b0) begin
         n_bad++;
         $display("FAIL sleep_partial: got %b want 0", all_sleep);
      end
      actor_sleep = '0;
      $display("test_sleep_rearm done: %0d compared", n_cmp);
   endtask

   task automatic test_sync_wait_mask();
      actor_sync_wait = 4'b1111;
      input_write = 2'b01;
      tick();
      n_cmp++;
      if ({all_sync, all_sync_wait, external_enqueue} !== 3'b101) begin
         n_bad++;
         $display("FAIL sync_wait_masked: got sync/wait/enq=%b want 101", {all_sync, all_sync_wait, external_enqueue});
      end
      actor_sync_wait = '0; input_write = '0; actor_sleep = 4'b1111;
      tick();
      actor_sleep = '0;
      tick();
      n_cmp++;
      if (external_enqueue !== 1'b0) begin
         n_bad++;
         $display("FAIL enqueue_cleared_by_sleep: got %b want 0", external_enqueue);
      end
      actor_sync_wait = 4'b1111;
      tick();
      actor_sync_wait = '0;
      n_cmp++;
      if ({all_sync, all_sync_wait} !== 2'b11) begin
         n_bad++;
         $display("FAIL sync_wait_clean: got sync/wait=%b want 11", {all_sync, all_sync_wait});
      end
      tick();
      $display("test_sync_wait_mask done: %0d compared", n_cmp);
   endtask

   task automatic test_set_wins();
      input_write = 2'b01;
      tick();
      input_write = '0; actor_sleep = 4'b1111;
      tick();
      n_cmp++;
      if ({all_sleep, external_enqueue} !== 2'b11) begin
         n_bad++;
         $display("FAIL sleep_with_pending: got sleep/enq=%b want 11", {all_sleep, external_enqueue});
      end
      actor_sleep = '0; input_write = 2'b10;
      tick();
      input_write = '0;
      tick();
      n_cmp++;
      if (external_enqueue !== 1'b1) begin
         n_bad++;
         $display("FAIL set_wins_over_clear: got %b want 1", external_enqueue);
      end
      $display("test_set_wins done: %0d compared", n_cmp);
   endtask

   task automatic test_done_rounds();
      logic [15:0] exp_rounds;
      actor_idle = '1;
      tick();
      actor_idle = '0;
      n_cmp++;
      if ({ap_done, ap_ready, ap_idle} !== 3'b110) begin
         n_bad++;
         $display("FAIL done_pulse: got done/ready/idle=%b want 110", {ap_done, ap_ready, ap_idle});
      end
      tick();
      n_cmp++;
      if ({ap_done, ap_idle, external_enqueue} !== 3'b010) begin
         n_bad++;
         $display("FAIL back_to_idle: got done/idle/enq=%b want 010", {ap_done, ap_idle, external_enqueue});
      end
      go_run();
      for (int r = 0; r < 3; r++) begin
         actor_sync_exec = 4'b1111;
         tick();
         actor_sync_exec = '0;
         tick();
      end
      actor_idle = '1;
      tick();
      actor_idle = '0;
      exp_rounds = STATS ? 16'd3 : 16'd0;
      n_cmp++;
      if ({ap_done, round_count} !== {1'b1, exp_rounds}) begin
         n_bad++;
         $display("FAIL rounds_at_done: got done=%b count=%0d want done=1 count=%0d", ap_done, round_count, exp_rounds);
      end
      tick();
      $display("test_done_rounds done: %0d compared", n_cmp);
   endtask

   task automatic test_reset_midrun();
      go_run();
      actor_sleep = 4'b1111; input_write = 2'b01; ap_rst = 1'b1;
      tick();
      ap_rst = 1'b0; actor_sleep = '0; input_write = '0;
      n_cmp++;
      if ({ap_idle, ap_done, ap_ready, trigger_start, all_sleep, all_sync, all_sync_wait, external_enqueue} !== 8'b1000_0000
          || round_count !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_midrun: got %b rounds=%0d want 10000000 rounds=0",
                  {ap_idle, ap_done, ap_ready, trigger_start, all_sleep, all_sync, all_sync_wait, external_enqueue}, round_count);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if ({ap_done, ap_idle} !== 2'b01) begin
            n_bad++;
            $display("FAIL no_done_after_reset: cycle %0d got done/idle=%b want 01", i, {ap_done, ap_idle});
         end
      end
      $display("test_reset_midrun done: %0d compared", n_cmp);
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         ap_rst          = ($urandom_range(0, 299) == 0);
         ap_start        = ($urandom_range(0, 2) == 0);
         actor_sleep     = ($urandom_range(0, 1) == 1) ? {NA{1'b1}} : NA'($urandom);
         actor_sync_exec = ($urandom_range(0, 2) == 0) ? {NA{1'b1}} : NA'($urandom);
         actor_sync_wait = ($urandom_range(0, 1) == 1) ? {NA{1'b1}} : NA'($urandom);
         actor_idle      = ($urandom_range(0, 9) == 0) ? {NA{1'b1}} : NA'($urandom);
         input_write     = ($urandom_range(0, 3) == 0) ? NI'($urandom) : '0;
         tick();
         n_cmp++;
         if ({ap_idle, trigger_start, ap_done, ap_ready} !==
             {m_phase == P_IDLE, m_phase == P_START, m_phase == P_DONE, m_phase == P_DONE}) begin
            n_bad++;
            $display("FAIL rand_handshake: cycle %0d got %b want phase %0d", c,
                     {ap_idle, trigger_start, ap_done, ap_ready}, m_phase);
         end
         n_cmp++;
         if ({all_sleep, all_sync, all_sync_wait, external_enqueue} !== {m_sleep, m_sync, m_syncw, m_pend}) begin
            n_bad++;
            $display("FAIL rand_aggregates: cycle %0d got %b want %b", c,
                     {all_sleep, all_sync, all_sync_wait, external_enqueue}, {m_sleep, m_sync, m_syncw, m_pend});
         end
         n_cmp++;
         if (round_count !== 16'(m_rounds)) begin
            n_bad++;
            $display("FAIL rand_rounds: cycle %0d got %0d want %0d", c, round_count, m_rounds);
         end
      end
      ap_rst = 1'b0; ap_start = 1'b0;
      $display("test_random done: %0d compared", n_cmp);
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_sleep_rearm();
      test_sync_wait_mask();
      test_set_wins();
      test_done_rounds();
      test_reset_midrun();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
